// File: rtl/logic_unit_pkg.sv
// Shared constants for the pipelined bitwise logic unit: op encoding and
// the output-register state type.
package logic_unit_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND    = 3'd0;
    localparam logic [OP_W-1:0] OP_OR     = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR    = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND   = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR    = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR   = 3'd5;
    localparam logic [OP_W-1:0] OP_PASS_A = 3'd6;
    localparam logic [OP_W-1:0] OP_NOT_A  = 3'd7;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/bitwise_op_core.sv
// Combinational WIDTH-bit bitwise operator with the legacy enable gate
// (enable low forces an all-zero result regardless of op).
import logic_unit_pkg::*;

module bitwise_op_core #(
    parameter int WIDTH = 4
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             enable_i,
    output logic [WIDTH-1:0] y_o
);

    logic [WIDTH-1:0] raw;

    always_comb begin
        raw = '0;
        case (op_i)
            OP_AND:    raw = a_i & b_i;
            OP_OR:     raw = a_i | b_i;
            OP_XOR:    raw = a_i ^ b_i;
            OP_NAND:   raw = ~(a_i & b_i);
            OP_NOR:    raw = ~(a_i | b_i);
            OP_XNOR:   raw = ~(a_i ^ b_i);
            OP_PASS_A: raw = a_i;
            OP_NOT_A:  raw = ~a_i;
            default:   raw = '0;
        endcase
        y_o = enable_i ? raw : '0;
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: one output register with flags behind a
// valid/ready handshake, an accumulator operand and a saturating counter.
import logic_unit_pkg::*;

module logic_unit_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_acc,
    input  logic             enable,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones,
    output logic [CNT_W-1:0] xfer_count
);

    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             ones_q, ones_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             xfer;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] result;

    assign out_valid  = (state_q == ST_FULL);
    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign xfer       = out_valid && out_ready;
    assign operand_b  = in_acc ? acc_q : in_b;
    assign out_y      = y_q;
    assign out_zero   = zero_q;
    assign out_ones   = ones_q;
    assign xfer_count = cnt_q;

    bitwise_op_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .op_i     (in_op),
        .a_i      (in_a),
        .b_i      (operand_b),
        .enable_i (enable),
        .y_o      (result)
    );

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        zero_d  = zero_q;
        ones_d  = ones_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        // Accept while FULL is only possible when the old result leaves the
        // same cycle, so a fresh load always means staying FULL.
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (accept) begin
                    state_d = ST_FULL;
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (accept) begin
            y_d    = result;
            zero_d = (result == '0);
            ones_d = (result == '1);
        end

        // A beat in the same cycle as acc_clr wins; the op already saw the old acc.
        if (accept) begin
            acc_d = result;
        end else if (acc_clr) begin
            acc_d = '0;
        end

        if (xfer && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            y_q     <= '0;
            zero_q  <= 1'b1;
            ones_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
            ones_q  <= ones_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
